key_debounce: RTL
=================

Name: key_debounce

Overview:
- Multi-channel push-button debouncer.
- Consumes the periodic one-cycle sample strobe from the team's tick generator (e.g. 2 ms at 12.5 MHz with extend 25000).
- Synchronises raw board inputs and accepts a new key level only after it has been stable for a set number of consecutive ticks.
- Outputs a clean level plus one-cycle press/release pulses to the CPU IO bus and the display logic.

Parameters:
- WIDTH, 5, number of independent key channels.
- STABLE_TICKS, 10, consecutive agreeing samples needed to accept a change; legal range 2..255; 10 x 2 ms = 20 ms.
- ACTIVE_LOW, 0, 1 = raw key reads 0 when pressed; the input is inverted before synchronising.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, reset, synchronous, active-low.
- tick, input, 1, sample strobe, one clk cycle wide, from the tick generator.
- key_in, input, WIDTH, raw asynchronous key pins.
- key_level, output, WIDTH, debounced level; 1 = pressed.
- key_press, output, WIDTH, one-cycle pulse on accepted 0->1 change.
- key_release, output, WIDTH, one-cycle pulse on accepted 1->0 change.

Behaviour:
- Reset: one clock, reset synchronous active-low; every register changes only on posedge clk.
- While rst_n=0 at a clock edge:
  - key_level=0, key_press=0, key_release=0.
  - Synchroniser flops = not pressed.
  - All channels go to S_LOW with count 0.
- Polarity: pressed = key_in ^ {WIDTH{ACTIVE_LOW}}. The result goes through a 2-flop synchroniser every clk, independent of tick. A raw change is visible to the FSM 2 clk edges later.
- Each channel is independent: own 4-state FSM and own counter of $clog2(STABLE_TICKS)+1 bits. The FSM only advances on edges where tick=1. With tick=0, state, count and key_level hold.
- FSM, with s = synchronised sample at that edge:
  - S_LOW, s=1: go to S_RISE, count=1.
  - S_LOW, s=0: stay.
  - S_RISE, s=0: go to S_LOW, count=0, no pulse (glitch rejected).
  - S_RISE, s=1, count==STABLE_TICKS-1: go to S_HIGH, key_level=1, key_press=1, count=0.
  - S_RISE, s=1, count below that: count+1.
  - S_HIGH, s=0: go to S_FALL, count=1.
  - S_HIGH, s=1: stay.
  - S_FALL, s=1: go to S_HIGH, count=0, no pulse.
  - S_FALL, s=0, count==STABLE_TICKS-1: go to S_LOW, key_level=0, key_release=1, count=0.
  - S_FALL, s=0, count below that: count+1.
- Result: a level change is accepted on exactly the STABLE_TICKS-th consecutive tick that samples the new value. key_level and the pulse update on that same edge, so the outputs are registered.
- Pulses: key_press and key_release are high for exactly one clk cycle, then clear on the next edge regardless of tick. They are never both high on one channel in the same cycle.
- tick held high continuously: every clk is a sample; behaviour stays correct with no skipped states.
- Multiple channels may accept changes on the same tick; pulses assert together.
- Reset asserted mid-count: the count is discarded and no pulse is produced. After release, a key already held needs a full STABLE_TICKS ticks, then gives a key_press.
- Counter never exceeds STABLE_TICKS-1; no wrap-around possible.

Test Plan:
(bench: WIDTH=2, STABLE_TICKS=4, ACTIVE_LOW=0, tick every 8 clk)
1. Reset, then key_in=2'b00 for 100 clk -> key_level=00; key_press and key_release never assert.
2. key_in[0] 0->1 and held -> key_level[0]=1 and key_press[0]=1 for exactly 1 clk, on the 4th tick edge after the sync delay; key_level[1] stays 0.
3. key_in[0] high for 2 ticks, low for 1, then high held -> no pulse at the first attempt; key_press[0] fires only after 4 further consecutive high ticks.
4. Hold key 0 pressed, then release -> key_release[0]=1 for 1 clk on the 4th low tick; key_level[0] returns to 0.
5. Both keys rise in the same cycle -> key_press=2'b11 in the same single cycle; key_level=2'b11.
6. rst_n=0 for 1 clk after 3 high ticks on key 0 -> outputs 0; with the key held, key_press[0] comes 4 ticks after reset release. Repeat with ACTIVE_LOW=1 and key_in=2'b11 idle -> key_level=00 after reset.

Source files
------------

// File: rtl/key_debounce.sv
// Multi-channel key debouncer: 2-flop synchroniser, then a per-channel FSM that only
// accepts a level after STABLE_TICKS consecutive agreeing tick samples.
module key_debounce #(
  parameter int WIDTH        = 5,
  parameter int STABLE_TICKS = 10,
  parameter int ACTIVE_LOW   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic [WIDTH-1:0] key_in,
  output logic [WIDTH-1:0] key_level,
  output logic [WIDTH-1:0] key_press,
  output logic [WIDTH-1:0] key_release
);

  localparam int CW = $clog2(STABLE_TICKS) + 1;
  localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);
  localparam logic [WIDTH-1:0] POL = {WIDTH{ACTIVE_LOW != 0}};

  typedef enum logic [1:0] {S_LOW, S_RISE, S_HIGH, S_FALL} state_t;

  logic [WIDTH-1:0] sync1, sync2;
  state_t           state     [WIDTH];
  state_t           state_nxt [WIDTH];
  logic [CW-1:0]    cnt       [WIDTH];
  logic [CW-1:0]    cnt_nxt   [WIDTH];
  logic [WIDTH-1:0] level_nxt, press_nxt, release_nxt;

  // Polarity is fixed before the synchroniser so reset value 0 always means "not pressed".
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= key_in ^ POL;
      sync2 <= sync1;
    end
  end

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      state_nxt[i]   = state[i];
      cnt_nxt[i]     = cnt[i];
      level_nxt[i]   = key_level[i];
      press_nxt[i]   = 1'b0;
      release_nxt[i] = 1'b0;
      if (tick) begin
        case (state[i])
          S_LOW: begin
            if (sync2[i]) begin
              state_nxt[i] = S_RISE;
              cnt_nxt[i]   = CW'(1);
            end
          end
          S_RISE: begin
            if (!sync2[i]) begin
              state_nxt[i] = S_LOW;
              cnt_nxt[i]   = '0;
            end else if (cnt[i] == LAST) begin
              state_nxt[i] = S_HIGH;
              cnt_nxt[i]   = '0;
              level_nxt[i] = 1'b1;
              press_nxt[i] = 1'b1;
            end else begin
              cnt_nxt[i] = cnt[i] + CW'(1);
            end
          end
          S_HIGH: begin
            if (!sync2[i]) begin
              state_nxt[i] = S_FALL;
              cnt_nxt[i]   = CW'(1);
            end
          end
          S_FALL: begin
            if (sync2[i]) begin
              state_nxt[i] = S_HIGH;
              cnt_nxt[i]   = '0;
            end else if (cnt[i] == LAST) begin
              state_nxt[i]   = S_LOW;
              cnt_nxt[i]     = '0;
              level_nxt[i]   = 1'b0;
              release_nxt[i] = 1'b1;
            end else begin
              cnt_nxt[i] = cnt[i] + CW'(1);
            end
          end
          default: begin
            state_nxt[i] = S_LOW;
            cnt_nxt[i]   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        state[i] <= S_LOW;
        cnt[i]   <= '0;
      end
      key_level   <= '0;
      key_press   <= '0;
      key_release <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        state[i] <= state_nxt[i];
        cnt[i]   <= cnt_nxt[i];
      end
      key_level   <= level_nxt;
      key_press   <= press_nxt;
      key_release <= release_nxt;
    end
  end

endmodule
